wb_initiator: RTL and testbench

- Wishbone classic single-transfer initiator (master).
- It is the opposite end of the slave port the multiplexer exposes to the management SoC.
- It lets on-chip logic, such as a debug or boot sequencer, issue 32-bit reads and writes onto a Wishbone bus through a valid/ready request/response interface.
- It includes an ack timeout and a saturating error counter.

---
 rtl/wb_initiator_pkg.sv | 28 ++
 rtl/wb_timeout_ctr.sv | 33 +++
 rtl/wb_initiator.sv | 145 ++++++++++++++
 tb/tb_wb_initiator.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_initiator_pkg.sv
// Shared types and widths for the Wishbone classic single-transfer initiator.
package wb_initiator_pkg;

  localparam int unsigned WB_ADR_W  = 32;
  localparam int unsigned WB_DAT_W  = 32;
  localparam int unsigned WB_SEL_W  = 4;
  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Captured request as presented on the Wishbone side.
  typedef struct packed {
    logic                we;
    logic [WB_SEL_W-1:0] sel;
    logic [WB_ADR_W-1:0] adr;
    logic [WB_DAT_W-1:0] dat;
  } wb_req_t;

  // Increment that sticks at all-ones.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Ack timeout counter for the Wishbone initiator.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   i_clear      - zero the counter
//   i_enable     - count this cycle (bus phase active)
//   o_expire_c   - combinational: this edge is the last allowed cycle without ack
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire_c
);

  // A limit of 0 means the timeout is disabled; LIMIT is unused in that case.
  localparam bit              ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] LIMIT   = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] r_cnt;

  // Counts bus cycles spent waiting for ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_cnt <= '0;
    else if (i_clear)  r_cnt <= '0;
    else if (i_enable) r_cnt <= r_cnt + TO_W'(1);
  end

  assign o_expire_c = ENABLED && i_enable && (r_cnt == LIMIT);

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator with valid/ready request and
// response channels, ack timeout and saturating timeout counter.
// Ports:
//   wb_clk_i, wb_rst_i              - clock, asynchronous active-high reset
//   req_valid/req_ready             - request handshake
//   req_we/adr/dat/sel              - request payload
//   rsp_valid/rsp_ready             - response handshake
//   rsp_dat, rsp_err                - read data (0 on write/timeout), timeout flag
//   err_count                       - saturating count of timeouts
//   wbm_*                           - Wishbone initiator interface
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [WB_ADR_W-1:0]  req_adr,
  input  logic [WB_DAT_W-1:0]  req_dat,
  input  logic [WB_SEL_W-1:0]  req_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WB_DAT_W-1:0]  rsp_dat,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [WB_SEL_W-1:0]  wbm_sel_o,
  output logic [WB_ADR_W-1:0]  wbm_adr_o,
  output logic [WB_DAT_W-1:0]  wbm_dat_o,
  input  logic [WB_DAT_W-1:0]  wbm_dat_i,
  input  logic                 wbm_ack_i
);

  state_t                r_state, w_state_nxt;
  wb_req_t               r_req, w_req_nxt;
  logic                  r_cyc, w_cyc_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [WB_DAT_W-1:0]   r_rsp_dat, w_rsp_dat_nxt;
  logic                  r_rsp_err, w_rsp_err_nxt;
  logic [ERR_CNT_W-1:0]  r_err_cnt, w_err_cnt_nxt;
  logic                  w_expire;
  logic                  w_accept;

  assign w_accept = (r_state == IDLE) && req_valid;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .i_clear    (w_accept),
    .i_enable   (r_state == BUS),
    .o_expire_c (w_expire)
  );

  // State and registered outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= IDLE;
      r_req       <= '0;
      r_cyc       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_req       <= w_req_nxt;
      r_cyc       <= w_cyc_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_dat   <= w_rsp_dat_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  // Next state. Ack takes priority over an expiring timeout.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (req_valid) w_state_nxt = BUS;
      BUS:     if (wbm_ack_i || w_expire) w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Next values of the output registers.
  always_comb begin
    w_req_nxt       = r_req;
    w_cyc_nxt       = r_cyc;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_dat_nxt   = r_rsp_dat;
    w_rsp_err_nxt   = r_rsp_err;
    w_err_cnt_nxt   = r_err_cnt;
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_req_nxt = '{we: req_we, sel: req_sel, adr: req_adr, dat: req_dat};
          w_cyc_nxt = 1'b1;
        end
      end
      BUS: begin
        if (wbm_ack_i) begin
          w_cyc_nxt       = 1'b0;
          w_req_nxt.we    = 1'b0;
          w_rsp_dat_nxt   = r_req.we ? '0 : wbm_dat_i;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
        end else if (w_expire) begin
          w_cyc_nxt       = 1'b0;
          w_req_nxt.we    = 1'b0;
          w_rsp_dat_nxt   = '0;
          w_rsp_err_nxt   = 1'b1;
          w_rsp_valid_nxt = 1'b1;
          w_err_cnt_nxt   = sat_inc(r_err_cnt);
        end
      end
      RESP: begin
        if (rsp_ready) w_rsp_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  assign req_ready = (r_state == IDLE);
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_req.we;
  assign wbm_sel_o = r_req.sel;
  assign wbm_adr_o = r_req.adr;
  assign wbm_dat_o = r_req.dat;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_err   = r_rsp_err;
  assign err_count = r_err_cnt;

endmodule

// File: tb/tb_wb_initiator.sv
// Self-checking bench for wb_initiator (timeout limit 4).
module tb_wb_initiator;
  import wb_initiator_pkg::*;

  localparam int unsigned TO    = 4;
  localparam int          NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr, req_dat;
  logic [3:0]  req_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic [7:0]  err_count;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;

  always #5 clk = ~clk;

  wb_initiator #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_dat   (req_dat),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .err_count (err_count),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i)
  );

  int checks = 0;
  int errors = 0;
  int model_err_cnt = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          wait_n;   // stb cycles before the ack cycle; NEVER = no ack
    logic [31:0] rd;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_cyc;
    int          exp_ecnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives one request through a slave that acks after wait_n wait states.
  // Called and returns at a falling edge.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input int wait_n, input logic [31:0] rd,
                      output logic [31:0] got_dat, output logic got_err, output int cyc_n);
    int   guard;
    logic bad;
    cyc_n = 0;
    bad   = 1'b0;
    chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    tick();
    req_valid = 1'b0;
    req_adr   = $urandom;
    guard     = 0;
    while (!rsp_valid && guard < 100) begin
      if (wbm_cyc_o && wbm_stb_o) begin
        cyc_n++;
        if (wbm_adr_o !== adr || wbm_dat_o !== dat || wbm_sel_o !== sel || wbm_we_o !== we)
          bad = 1'b1;
        wbm_ack_i = (cyc_n == wait_n + 1);
        wbm_dat_i = wbm_ack_i ? rd : $urandom;
      end else begin
        bad       = 1'b1;
        wbm_ack_i = 1'b0;
      end
      tick();
      guard++;
    end
    wbm_ack_i = 1'b0;
    chk("rsp_valid_seen", {31'b0, rsp_valid}, 32'd1);
    chk("bus_stable_no_gap", {31'b0, bad}, 32'd0);
    chk("cyc_low_in_resp", {30'b0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("we_low_in_resp", {31'b0, wbm_we_o}, 32'd0);
    chk("req_ready_resp", {31'b0, req_ready}, 32'd0);
    got_dat = rsp_dat;
    got_err = rsp_err;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_cleared", {31'b0, rsp_valid}, 32'd0);
  endtask

  task automatic check_xfer(input string tag, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel, input int wait_n,
                            input logic [31:0] rd, input logic [31:0] exp_dat,
                            input logic exp_err, input int exp_cyc, input int exp_ecnt);
    logic [31:0] gd;
    logic        ge;
    int          cn;
    xfer(we, adr, dat, sel, wait_n, rd, gd, ge, cn);
    chk({tag, "_rsp_dat"}, gd, exp_dat);
    chk({tag, "_rsp_err"}, {31'b0, ge}, {31'b0, exp_err});
    chk({tag, "_cyc_cycles"}, 32'(cn), 32'(exp_cyc));
    chk({tag, "_err_count"}, {24'b0, err_count}, 32'(exp_ecnt));
  endtask

  // Reference: ack inside the first TO stb cycles completes normally,
  // otherwise the bus is held exactly TO cycles and an error is reported.
  task automatic model_xfer(input string tag, input logic we, input logic [31:0] adr,
                            input logic [31:0] dat, input logic [3:0] sel, input int wait_n,
                            input logic [31:0] rd);
    logic [31:0] ed;
    logic        ee;
    int          ec;
    if (wait_n + 1 <= int'(TO)) begin
      ed = we ? 32'd0 : rd;
      ee = 1'b0;
      ec = wait_n + 1;
    end else begin
      ed = 32'd0;
      ee = 1'b1;
      ec = int'(TO);
      model_err_cnt = (model_err_cnt >= 255) ? 255 : model_err_cnt + 1;
    end
    check_xfer(tag, we, adr, dat, sel, wait_n, rd, ed, ee, ec, model_err_cnt);
  endtask

  initial begin
    logic [31:0] hold_dat;

    vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0,     32'h0,          32'h0,          1'b0, 1, 0};
    vecs[1] = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, 3,     32'h1234_5678,  32'h1234_5678,  1'b0, 4, 0};
    vecs[2] = '{1'b0, 32'h1000_0000, 32'h0,         4'hF, NEVER, 32'h0,          32'h0,          1'b1, 4, 1};
    vecs[3] = '{1'b0, 32'h2000_0010, 32'h0,         4'h3, 3,     32'hCAFE_F00D,  32'hCAFE_F00D,  1'b0, 4, 1};
    vecs[4] = '{1'b1, 32'h4000_0000, 32'h55AA_55AA, 4'h5, 2,     32'hFFFF_FFFF,  32'h0,          1'b0, 3, 1};
    vecs[5] = '{1'b1, 32'h4000_0004, 32'h1111_2222, 4'hC, 4,     32'h0,          32'h0,          1'b1, 4, 2};
    vecs[6] = '{1'b0, 32'h5000_0000, 32'h0,         4'h1, 0,     32'hA5A5_A5A5,  32'hA5A5_A5A5,  1'b0, 1, 2};

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0; req_sel = '0;
    rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    #1;
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_bus_ctl", {29'b0, wbm_cyc_o, wbm_stb_o, wbm_we_o}, 32'd0);
    chk("reset_adr", wbm_adr_o, 32'd0);
    chk("reset_dat", wbm_dat_o, 32'd0);
    chk("reset_sel", {28'b0, wbm_sel_o}, 32'd0);
    chk("reset_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
    chk("reset_rsp_dat", rsp_dat, 32'd0);
    chk("reset_err_count", {24'b0, err_count}, 32'd0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 7; i++)
      check_xfer($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                 vecs[i].wait_n, vecs[i].rd, vecs[i].exp_dat, vecs[i].exp_err,
                 vecs[i].exp_cyc, vecs[i].exp_ecnt);
    model_err_cnt = 2;

    // Stray ack while idle is ignored.
    wbm_ack_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stray_ack_cyc", {31'b0, wbm_cyc_o}, 32'd0);
      chk("stray_ack_rsp", {31'b0, rsp_valid}, 32'd0);
    end
    wbm_ack_i = 1'b0;

    // Backpressure: response held, new request waits.
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h6000_0000; req_sel = 4'hF;
    tick();
    chk("bp_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h0F0F_1234;
    req_we = 1'b1; req_adr = 32'h6000_0040; req_dat = 32'h7777_8888; req_sel = 4'h9;
    tick();
    wbm_ack_i = 1'b0;
    hold_dat = 32'h0F0F_1234;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rsp_dat", rsp_dat, hold_dat);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_no_cyc", {31'b0, wbm_cyc_o}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_released", {29'b0, rsp_valid, wbm_cyc_o, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("bp_second_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    chk("bp_second_adr", wbm_adr_o, 32'h6000_0040);
    chk("bp_second_we", {31'b0, wbm_we_o}, 32'd1);
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    chk("bp_second_rsp", {31'b0, rsp_valid}, 32'd1);
    chk("bp_second_dat", rsp_dat, 32'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Randomized transfers against the reference model.
    for (int i = 0; i < 40; i++)
      model_xfer("rand", 1'($urandom), $urandom, $urandom, 4'($urandom),
                 int'($urandom_range(0, 6)), $urandom);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++)
      model_xfer("sat", 1'b0, $urandom, 32'h0, 4'hF, NEVER, 32'h0);
    chk("err_count_saturated", {24'b0, err_count}, 32'd255);

    // Asynchronous reset in the middle of a bus cycle.
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h7000_0000; req_dat = 32'h1; req_sel = 4'hF;
    tick();
    req_valid = 1'b0;
    chk("arst_pre_cyc", {31'b0, wbm_cyc_o}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cyc_stb", {30'b0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    chk("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("arst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("arst_err_count", {24'b0, err_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_err_cnt = 0;
    tick();
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
    model_xfer("post_rst", 1'b0, 32'h7000_0008, 32'h0, 4'hF, 1, 32'h89AB_CDEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
